hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// - Controller-side consumer of the decode stage's Controller modport (rs1Addr, rs2Addr, aluOp1Type, aluOp2Type, isStore).
// - Shadows dest-reg info of in-flight instrs (EX/MEM/WB), detects load-use hazards, generates stall/flush.
// - Emits registered forwarding selects to the execute stage; counts stall/flush cycles for perf debug.
// - Sits beside the 5-stage pipeline; sole source of pipeline stall/flush control.
// PARAMETERS
// - PERF_CNT_WIDTH  32  width of stallCount/flushCount (saturating)
// PORTS
// - clk             in   1    single clock, all state on rising edge
// - rst             in   1    synchronous, active-high reset
// - rs1Addr         in   5    decode src1 reg addr (RegAddr)
// - rs2Addr         in   5    decode src2 reg addr (RegAddr)
// - aluOp1Type      in   ALUOpType  OP_TYPE_REG => rs1 is read
// - aluOp2Type      in   ALUOpType  OP_TYPE_REG => rs2 is read
// - isStore         in   1    store: rs2 is read regardless of aluOp2Type
// - decodeValid     in   1    decode holds a real instr (0 = bubble)
// - rdAddr          in   5    decode dest reg
// - wrEnable        in   1    decode instr writes rdAddr
// - isLoad          in   1    decode instr is a load
// - exBusy          in   1    EX unit multi-cycle op in progress
// - redirectValid   in   1    EX resolved taken branch/jump this cycle
// - stallFetch      out  1    hold PC and IF/ID reg
// - stallDecode     out  1    hold ID/EX inputs (insert bubble)
// - flushDecode     out  1    squash IF/ID contents
// - flushExecute    out  1    squash instr entering EX
// - rs1FwdSel       out  ForwardSel  registered, applies to instr in EX
// - rs2FwdSel       out  ForwardSel  registered, applies to instr in EX
// - stallCount      out  PERF_CNT_WIDTH  cycles with load-use or exBusy stall
// - flushCount      out  PERF_CNT_WIDTH  cycles with redirectValid
// BEHAVIOUR
// - Reset: all shadow entries valid=0; all outputs 0; fwd selects FWD_NONE; counters 0.
// - Shadow regs exEnt/memEnt/wbEnt = {valid, rd, wr, load}; entries with rd==0 never match.
// - Source used: rs1 iff aluOp1Type==OP_TYPE_REG; rs2 iff aluOp2Type==OP_TYPE_REG or isStore.
// - loadUse = decodeValid & exEnt.valid & exEnt.load & exEnt.wr & used src == exEnt.rd (rd!=0).
// - Priority (combinational outputs): exBusy > redirectValid > loadUse.
//   - exBusy: stallFetch=stallDecode=1, no flush; all shadow regs and fwd selects hold.
//   - redirectValid (no exBusy): flushDecode=flushExecute=1, stalls 0; loadUse ignored.
//   - loadUse only: stallFetch=stallDecode=1, flushExecute=1 (bubble), exactly 1 stall cycle.
// - Advance (every cycle unless exBusy): wbEnt<=memEnt; memEnt<=exEnt;
//   exEnt<=decode info if decodeValid & !flushExecute, else valid=0.
// - Forward (computed from pre-advance state, registered with exEnt): per used src,
//   match exEnt -> FWD_FROM_MEM; else match memEnt -> FWD_FROM_WB; else FWD_NONE.
//   Youngest producer wins; unused src -> FWD_NONE; bubble in EX -> FWD_NONE.
// - wbEnt match needs no forward: register file is write-first.
// - Load-use latency: load at EX cycle n -> consumer stalls in ID at n, enters EX at n+2, rs*FwdSel=FWD_FROM_WB.
// - Counters: +1 per qualifying cycle, saturate at all-ones; never wrap.
// - rst asserted mid-stall/flush: next cycle all state as at reset, no residual stall.
// STRUCTURE
// - PipelineTypes: ForwardSel enum {FWD_NONE, FWD_FROM_MEM, FWD_FROM_WB};
//   HazardEntry struct {valid, rd, wr, load}.
// - BasicTypes: RegAddr, ALUOpType (OP_TYPE_REG).
// - One sub-module: hazard_forward_select (combinational src-vs-entry match -> ForwardSel),
//   instantiated once per source.
// TESTING
// - Load x5 then add x6,x5,x1: 1 stall cycle, bubble in EX; add in EX with rs1FwdSel=FWD_FROM_WB; stallCount=1.
// - addi x5 then sub x7,x5,x5: no stall; both selects FWD_FROM_MEM next cycle.
// - Load x0 then use x0: no stall, FWD_NONE.
// - Store sw x5 with aluOp2Type=IMM after load x5: stall (isStore marks rs2 used).
// - redirectValid with simultaneous loadUse: flushDecode=flushExecute=1, stalls 0, flushCount+1.
// - exBusy 3 cycles mid-forwarding: shadow regs and selects frozen, stallCount+3; rst during busy clears all.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: register addresses, ALU operand kinds,
// forwarding selects and the shadow entry tracking an in-flight instruction.
package hazard_controller_pkg;

   typedef logic [4:0] RegAddr;

   typedef enum logic [1:0] {
      OP_TYPE_REG  = 2'd0,
      OP_TYPE_IMM  = 2'd1,
      OP_TYPE_PC   = 2'd2,
      OP_TYPE_ZERO = 2'd3
   } ALUOpType;

   typedef enum logic [1:0] {
      FWD_NONE     = 2'd0,
      FWD_FROM_MEM = 2'd1,
      FWD_FROM_WB  = 2'd2
   } ForwardSel;

   typedef struct packed {
      logic   valid;
      RegAddr rd;
      logic   wr;
      logic   load;
   } HazardEntry;

   localparam HazardEntry ENTRY_EMPTY = '0;

   // x0 is hardwired, so a producer targeting it never supplies a value.
   function automatic logic entry_match(input HazardEntry ent, input RegAddr src);
      return ent.valid && ent.wr && (ent.rd != 5'd0) && (ent.rd == src);
   endfunction

endpackage

// File: rtl/hazard_forward_select.sv
// Forwarding select for one decode source against the EX and MEM shadow entries.
// Combinational, no backpressure; the youngest producer (EX) wins.
module hazard_forward_select
   import hazard_controller_pkg::*;
(
   input  logic       src_used_i,
   input  RegAddr     src_addr_i,
   input  HazardEntry ex_ent_i,
   input  HazardEntry mem_ent_i,
   output ForwardSel  fwd_sel_o
);

   always_comb begin
      fwd_sel_o = FWD_NONE;
      if (src_used_i) begin
         if (entry_match(ex_ent_i, src_addr_i)) begin
            fwd_sel_o = FWD_FROM_MEM;
         end else if (entry_match(mem_ent_i, src_addr_i)) begin
            fwd_sel_o = FWD_FROM_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush and registered forwarding control for the 5-stage core.
// Stall/flush are combinational this cycle; forwarding selects apply to the instr in EX next cycle.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int PERF_CNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  RegAddr                    rs1Addr,
   input  RegAddr                    rs2Addr,
   input  ALUOpType                  aluOp1Type,
   input  ALUOpType                  aluOp2Type,
   input  logic                      isStore,
   input  logic                      decodeValid,
   input  RegAddr                    rdAddr,
   input  logic                      wrEnable,
   input  logic                      isLoad,
   input  logic                      exBusy,
   input  logic                      redirectValid,
   output logic                      stallFetch,
   output logic                      stallDecode,
   output logic                      flushDecode,
   output logic                      flushExecute,
   output ForwardSel                 rs1FwdSel,
   output ForwardSel                 rs2FwdSel,
   output logic [PERF_CNT_WIDTH-1:0] stallCount,
   output logic [PERF_CNT_WIDTH-1:0] flushCount
);

   HazardEntry ex_ent_q, mem_ent_q, wb_ent_q;
   HazardEntry ex_ent_d, mem_ent_d, wb_ent_d;
   ForwardSel  rs1_fwd_q, rs2_fwd_q, rs1_fwd_d, rs2_fwd_d;
   ForwardSel  rs1_sel, rs2_sel;
   logic [PERF_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic rs1_used, rs2_used, load_use;

   assign rs1_used = (aluOp1Type == OP_TYPE_REG);
   assign rs2_used = (aluOp2Type == OP_TYPE_REG) || isStore;

   assign load_use = decodeValid && ex_ent_q.load &&
                     ((rs1_used && entry_match(ex_ent_q, rs1Addr)) ||
                      (rs2_used && entry_match(ex_ent_q, rs2Addr)));

   hazard_forward_select u_fwd_rs1 (
      .src_used_i (rs1_used),
      .src_addr_i (rs1Addr),
      .ex_ent_i   (ex_ent_q),
      .mem_ent_i  (mem_ent_q),
      .fwd_sel_o  (rs1_sel)
   );

   hazard_forward_select u_fwd_rs2 (
      .src_used_i (rs2_used),
      .src_addr_i (rs2Addr),
      .ex_ent_i   (ex_ent_q),
      .mem_ent_i  (mem_ent_q),
      .fwd_sel_o  (rs2_sel)
   );

   // Control priority: busy EX unit, then branch redirect, then load-use bubble.
   always_comb begin
      stallFetch   = 1'b0;
      stallDecode  = 1'b0;
      flushDecode  = 1'b0;
      flushExecute = 1'b0;
      if (!rst) begin
         if (exBusy) begin
            stallFetch  = 1'b1;
            stallDecode = 1'b1;
         end else if (redirectValid) begin
            flushDecode  = 1'b1;
            flushExecute = 1'b1;
         end else if (load_use) begin
            stallFetch   = 1'b1;
            stallDecode  = 1'b1;
            flushExecute = 1'b1;
         end
      end
   end

   always_comb begin
      ex_ent_d  = ex_ent_q;
      mem_ent_d = mem_ent_q;
      wb_ent_d  = wb_ent_q;
      rs1_fwd_d = rs1_fwd_q;
      rs2_fwd_d = rs2_fwd_q;
      if (!exBusy) begin
         wb_ent_d  = mem_ent_q;
         mem_ent_d = ex_ent_q;
         if (decodeValid && !flushExecute) begin
            ex_ent_d  = '{valid: 1'b1, rd: rdAddr, wr: wrEnable, load: isLoad};
            rs1_fwd_d = rs1_sel;
            rs2_fwd_d = rs2_sel;
         end else begin
            ex_ent_d  = ENTRY_EMPTY;
            rs1_fwd_d = FWD_NONE;
            rs2_fwd_d = FWD_NONE;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stallDecode && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (redirectValid && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ent_q    <= ENTRY_EMPTY;
         mem_ent_q   <= ENTRY_EMPTY;
         wb_ent_q    <= ENTRY_EMPTY;
         rs1_fwd_q   <= FWD_NONE;
         rs2_fwd_q   <= FWD_NONE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_ent_q    <= ex_ent_d;
         mem_ent_q   <= mem_ent_d;
         wb_ent_q    <= wb_ent_d;
         rs1_fwd_q   <= rs1_fwd_d;
         rs2_fwd_q   <= rs2_fwd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign rs1FwdSel  = rs1_fwd_q;
   assign rs2FwdSel  = rs2_fwd_q;
   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed checks of hazard_controller: load-use stall, forwarding, x0, stores, redirect, busy, reset, saturation.
module tb_hazard_controller;
   import hazard_controller_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   RegAddr        rs1Addr, rs2Addr, rdAddr;
   ALUOpType      aluOp1Type, aluOp2Type;
   logic          isStore, decodeValid, wrEnable, isLoad, exBusy, redirectValid;
   logic          stallFetch, stallDecode, flushDecode, flushExecute;
   ForwardSel     rs1FwdSel, rs2FwdSel;
   logic [CW-1:0] stallCount, flushCount;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_controller #(.PERF_CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .rs1Addr       (rs1Addr),
      .rs2Addr       (rs2Addr),
      .aluOp1Type    (aluOp1Type),
      .aluOp2Type    (aluOp2Type),
      .isStore       (isStore),
      .decodeValid   (decodeValid),
      .rdAddr        (rdAddr),
      .wrEnable      (wrEnable),
      .isLoad        (isLoad),
      .exBusy        (exBusy),
      .redirectValid (redirectValid),
      .stallFetch    (stallFetch),
      .stallDecode   (stallDecode),
      .flushDecode   (flushDecode),
      .flushExecute  (flushExecute),
      .rs1FwdSel     (rs1FwdSel),
      .rs2FwdSel     (rs2FwdSel),
      .stallCount    (stallCount),
      .flushCount    (flushCount)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic v, input RegAddr r1, input RegAddr r2, input ALUOpType o1,
                      input ALUOpType o2, input logic st, input RegAddr rd, input logic wr,
                      input logic ld);
      decodeValid = v;  rs1Addr = r1;  rs2Addr = r2;  aluOp1Type = o1;  aluOp2Type = o2;
      isStore     = st; rdAddr  = rd;  wrEnable = wr; isLoad     = ld;
      #1;
   endtask

   task automatic ctl(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
      check({tag, ".stallFetch"},   32'(stallFetch),   32'(sf));
      check({tag, ".stallDecode"},  32'(stallDecode),  32'(sd));
      check({tag, ".flushDecode"},  32'(flushDecode),  32'(fd));
      check({tag, ".flushExecute"}, 32'(flushExecute), 32'(fe));
   endtask

   task automatic fwd(input string tag, input ForwardSel e1, input ForwardSel e2);
      check({tag, ".rs1FwdSel"}, 32'(rs1FwdSel), 32'(e1));
      check({tag, ".rs2FwdSel"}, 32'(rs2FwdSel), 32'(e2));
   endtask

   initial begin
      rst = 1'b1; exBusy = 1'b0; redirectValid = 1'b0;
      dec(0, 0, 0, OP_TYPE_IMM, OP_TYPE_IMM, 0, 0, 0, 0);
      step(); step();
      rst = 1'b0; #1;
      ctl("reset", 0, 0, 0, 0);
      fwd("reset", FWD_NONE, FWD_NONE);
      check("reset.stallCount", 32'(stallCount), 0);
      check("reset.flushCount", 32'(flushCount), 0);

      // lw x5 ; add x6,x5,x1
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 1);
      ctl("lw_issue", 0, 0, 0, 0);
      step();
      dec(1, 5, 1, OP_TYPE_REG, OP_TYPE_REG, 0, 6, 1, 0);
      ctl("loaduse", 1, 1, 0, 1);
      step();
      ctl("loaduse_one_cycle", 0, 0, 0, 0);
      fwd("loaduse_bubble", FWD_NONE, FWD_NONE);
      step();
      fwd("loaduse_fwd", FWD_FROM_WB, FWD_NONE);
      check("loaduse.stallCount", 32'(stallCount), 1);

      // addi x5,x0,imm ; sub x7,x5,x5 ; or x8,x5,x7
      dec(1, 0, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 0);
      step();
      dec(1, 5, 5, OP_TYPE_REG, OP_TYPE_REG, 0, 7, 1, 0);
      ctl("alu_dep", 0, 0, 0, 0);
      step();
      fwd("alu_dep", FWD_FROM_MEM, FWD_FROM_MEM);
      dec(1, 5, 7, OP_TYPE_REG, OP_TYPE_REG, 0, 8, 1, 0);
      step();
      fwd("two_producers", FWD_FROM_WB, FWD_FROM_MEM);
      check("alu_dep.stallCount", 32'(stallCount), 1);

      // lw x0 ; add x9,x0,x0
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 0, 1, 1);
      step();
      dec(1, 0, 0, OP_TYPE_REG, OP_TYPE_REG, 0, 9, 1, 0);
      ctl("x0_use", 0, 0, 0, 0);
      step();
      fwd("x0_use", FWD_NONE, FWD_NONE);

      // lw x5 ; sw x5,0(x2) with rs2 marked used only by isStore
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 1);
      step();
      dec(1, 2, 5, OP_TYPE_REG, OP_TYPE_IMM, 1, 0, 0, 0);
      ctl("store_loaduse", 1, 1, 0, 1);
      step();
      step();
      fwd("store_fwd", FWD_NONE, FWD_FROM_WB);
      check("store.stallCount", 32'(stallCount), 2);

      // lw x5 ; addi x9,x1,imm whose unused rs2 field happens to be x5
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 1);
      step();
      dec(1, 1, 5, OP_TYPE_REG, OP_TYPE_IMM, 0, 9, 1, 0);
      ctl("unused_src", 0, 0, 0, 0);
      step();
      fwd("unused_src", FWD_NONE, FWD_NONE);

      // lw x5 ; add x6,x5,x1 while EX redirects
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 1);
      step();
      dec(1, 5, 1, OP_TYPE_REG, OP_TYPE_REG, 0, 6, 1, 0);
      redirectValid = 1'b1; #1;
      ctl("redirect", 0, 0, 1, 1);
      step();
      redirectValid = 1'b0; #1;
      check("redirect.flushCount", 32'(flushCount), 1);
      check("redirect.stallCount", 32'(stallCount), 2);
      fwd("redirect_bubble", FWD_NONE, FWD_NONE);

      // addi x5 ; add x6,x5,x5 ; then EX busy 3 cycles with sub x12,x6,x5 waiting
      dec(1, 0, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 0);
      step();
      dec(1, 5, 5, OP_TYPE_REG, OP_TYPE_REG, 0, 6, 1, 0);
      step();
      fwd("pre_busy", FWD_FROM_MEM, FWD_FROM_MEM);
      dec(1, 6, 5, OP_TYPE_REG, OP_TYPE_REG, 0, 12, 1, 0);
      exBusy = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         ctl("busy", 1, 1, 0, 0);
         step();
         fwd("busy_hold", FWD_FROM_MEM, FWD_FROM_MEM);
      end
      check("busy.stallCount", 32'(stallCount), 5);
      exBusy = 1'b0; #1;
      ctl("busy_release", 0, 0, 0, 0);
      step();
      fwd("busy_frozen_shadow", FWD_FROM_MEM, FWD_FROM_WB);

      // lw x5 in EX, busy, reset during busy
      dec(1, 1, 0, OP_TYPE_REG, OP_TYPE_IMM, 0, 5, 1, 1);
      step();
      dec(1, 5, 5, OP_TYPE_REG, OP_TYPE_REG, 0, 6, 1, 0);
      exBusy = 1'b1; #1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; exBusy = 1'b0; #1;
      ctl("rst_busy", 0, 0, 0, 0);
      fwd("rst_busy", FWD_NONE, FWD_NONE);
      check("rst_busy.stallCount", 32'(stallCount), 0);
      check("rst_busy.flushCount", 32'(flushCount), 0);

      // Counter saturation
      dec(0, 0, 0, OP_TYPE_IMM, OP_TYPE_IMM, 0, 0, 0, 0);
      exBusy = 1'b1;
      for (int i = 0; i < 20; i++) step();
      exBusy = 1'b0; redirectValid = 1'b1;
      for (int i = 0; i < 20; i++) step();
      redirectValid = 1'b0; #1;
      check("sat.stallCount", 32'(stallCount), 15);
      check("sat.flushCount", 32'(flushCount), 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
